// File: rtl/edge_scan_controller.sv
// Raster-scan read sequencer for the 3x3 edge-detection datapath.
// Issues pixel reads, tracks the returned pixel position and flags interior window centres.
module edge_scan_controller #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pix_valid,
  output logic              win_valid,
  output logic [ADDR_W-1:0] out_addr
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic              pix_q;
  logic              win_q;

  logic abort_hit;
  logic col_last;
  logic row_last;
  logic last_read;
  logic win_hit;

  // Abort only matters while a frame is in flight.
  assign abort_hit = abort & ((state == S_RUN) | (state == S_DRAIN));

  // A read is issued every RUN cycle the consumer can take a window next cycle.
  assign rd_en     = (state == S_RUN) & out_ready & ~abort & ~reset;
  assign rd_addr   = addr;

  assign col_last  = (col == COL_W'(IMG_W - 1));
  assign row_last  = (row == ROW_W'(IMG_H - 1));
  assign last_read = rd_en & col_last & row_last;

  // The pixel being read closes a window when it sits at row>=2 and col>=2;
  // its centre is one row up and one column left, i.e. addr - (IMG_W + 1).
  assign win_hit   = rd_en & (row >= ROW_W'(2)) & (col >= COL_W'(2));

  // In-flight return data is dropped in the same cycle an abort lands.
  assign pix_valid = pix_q & ~abort_hit;
  assign win_valid = win_q & ~abort_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      addr     <= '0;
      pix_q    <= 1'b0;
      win_q    <= 1'b0;
      out_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      pix_q <= rd_en;
      win_q <= win_hit;
      done  <= 1'b0;
      if (win_hit) begin
        out_addr <= addr - ADDR_W'(IMG_W + 1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
            addr  <= '0;
          end
        end

        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            row   <= '0;
            col   <= '0;
            addr  <= '0;
            pix_q <= 1'b0;
            win_q <= 1'b0;
          end else if (last_read) begin
            state <= S_DRAIN;
            row   <= '0;
            col   <= '0;
            addr  <= '0;
          end else if (rd_en) begin
            addr <= addr + ADDR_W'(1);
            if (col_last) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end

        S_DRAIN: begin
          busy <= 1'b0;
          if (abort) begin
            state <= S_IDLE;
            pix_q <= 1'b0;
            win_q <= 1'b0;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_scan_controller.sv
// Directed bench for edge_scan_controller: a 4x4 instance driven from cycle tables
// and a 5x3 instance exercised by a hand-written frame walk.
module tb_edge_scan_controller;

  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic          abort;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          pix_valid;
  logic          win_valid;
  logic [AW-1:0] out_addr;

  logic          s_start;
  logic          s_abort;
  logic          s_ready;
  logic          s_busy;
  logic          s_done;
  logic          s_rd_en;
  logic [AW-1:0] s_rd_addr;
  logic          s_pix;
  logic          s_win;
  logic [AW-1:0] s_out_addr;

  edge_scan_controller #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .pix_valid (pix_valid),
    .win_valid (win_valid),
    .out_addr  (out_addr)
  );

  edge_scan_controller #(.IMG_W(5), .IMG_H(3), .ADDR_W(AW)) u_dut53 (
    .clk       (clk),
    .reset     (reset),
    .start     (s_start),
    .abort     (s_abort),
    .out_ready (s_ready),
    .busy      (s_busy),
    .done      (s_done),
    .rd_en     (s_rd_en),
    .rd_addr   (s_rd_addr),
    .pix_valid (s_pix),
    .win_valid (s_win),
    .out_addr  (s_out_addr)
  );

  typedef struct {
    logic rst;
    logic st;
    logic ab;
    logic rdy;
    logic e_en;
    int   e_ra;
    logic e_pv;
    logic e_wv;
    int   e_oa;
    logic e_bz;
    logic e_dn;
    logic full;
  } vec_t;

  vec_t vq[$];
  int   wins[$];
  int   prev_rd;
  int   n_cmp;
  int   n_bad;
  int   exp4[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // 4x4 frame: a pixel at linear address a closes a window if row>=2 and col>=2.
  function automatic logic is_win(input int a);
    return (a >= 0) && ((a / 4) >= 2) && ((a % 4) >= 2);
  endfunction

  function automatic int ctr(input int a);
    return (a / 4 - 1) * 4 + (a % 4 - 1);
  endfunction

  task automatic add(input logic rst, input logic st, input logic ab, input logic rdy,
                     input logic e_en, input int e_ra, input logic e_pv, input logic e_wv,
                     input int e_oa, input logic e_bz, input logic e_dn, input logic full);
    vec_t v;
    v.rst = rst; v.st = st; v.ab = ab; v.rdy = rdy;
    v.e_en = e_en; v.e_ra = e_ra; v.e_pv = e_pv; v.e_wv = e_wv;
    v.e_oa = e_oa; v.e_bz = e_bz; v.e_dn = e_dn; v.full = full;
    vq.push_back(v);
  endtask

  task automatic v_idle(input logic st, input logic ab, input logic full);
    add(1'b0, st, ab, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, full);
    prev_rd = -1;
  endtask

  task automatic v_read(input int a, input logic st);
    add(1'b0, st, 1'b0, 1'b1, 1'b1, a, prev_rd >= 0, is_win(prev_rd), ctr(prev_rd),
        1'b1, 1'b0, 1'b0);
    prev_rd = a;
  endtask

  task automatic v_stall();
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, prev_rd >= 0, is_win(prev_rd), ctr(prev_rd),
        1'b1, 1'b0, 1'b0);
    prev_rd = -1;
  endtask

  task automatic v_drain();
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, prev_rd >= 0, is_win(prev_rd), ctr(prev_rd),
        1'b1, 1'b0, 1'b0);
    prev_rd = -1;
  endtask

  task automatic v_done(input logic st);
    add(1'b0, st, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    prev_rd = -1;
  endtask

  task automatic run_vecs(input string tag);
    wins.delete();
    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      reset     = vq[i].rst;
      start     = vq[i].st;
      abort     = vq[i].ab;
      out_ready = vq[i].rdy;
      @(negedge clk);
      chk($sformatf("%s[%0d].rd_en", tag, i), 32'(rd_en), 32'(vq[i].e_en));
      chk($sformatf("%s[%0d].pix_valid", tag, i), 32'(pix_valid), 32'(vq[i].e_pv));
      chk($sformatf("%s[%0d].win_valid", tag, i), 32'(win_valid), 32'(vq[i].e_wv));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(vq[i].e_bz));
      chk($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(vq[i].e_dn));
      if (vq[i].e_en || vq[i].full)
        chk($sformatf("%s[%0d].rd_addr", tag, i), 32'(rd_addr), 32'(vq[i].e_ra));
      if (vq[i].e_wv || vq[i].full)
        chk($sformatf("%s[%0d].out_addr", tag, i), 32'(out_addr), 32'(vq[i].e_oa));
      if (win_valid === 1'b1) wins.push_back(int'(out_addr));
    end
    vq.delete();
  endtask

  task automatic chk_wins4(input string tag);
    chk($sformatf("%s.win_count", tag), 32'(wins.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.win_addr%0d", tag, i),
          (i < wins.size()) ? 32'(wins[i]) : 32'hffff_ffff, 32'(exp4[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rq[$];
    int wq[$];
    int done_at;
    int ndone;
    int exp53[3];

    n_cmp     = 0;
    n_bad     = 0;
    prev_rd   = -1;
    exp4      = '{5, 6, 9, 10};
    exp53     = '{6, 7, 8};
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    s_start   = 1'b0;
    s_abort   = 1'b0;
    s_ready   = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state: every output zero.
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    v_idle(1'b0, 1'b0, 1'b1);
    run_vecs("reset");

    // Plain 4x4 frame, done at t0+18.
    v_idle(1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 16; a++) v_read(a, 1'b0);
    v_drain();
    v_done(1'b0);
    v_idle(1'b0, 1'b0, 1'b0);
    run_vecs("frame");
    chk_wins4("frame");

    // Three-cycle stall after address 6, done at t0+21.
    v_idle(1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 7; a++) v_read(a, 1'b0);
    v_stall();
    v_stall();
    v_stall();
    for (int a = 7; a < 16; a++) v_read(a, 1'b0);
    v_drain();
    v_done(1'b0);
    v_idle(1'b0, 1'b0, 1'b0);
    run_vecs("stall");
    chk_wins4("stall");

    // Abort right after address 9 is read.
    v_idle(1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 10; a++) v_read(a, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    prev_rd = -1;
    v_idle(1'b0, 1'b0, 1'b0);
    v_idle(1'b0, 1'b0, 1'b0);
    v_idle(1'b0, 1'b0, 1'b0);
    run_vecs("abort");
    chk("abort.win_count", 32'(wins.size()), 32'd0);

    // Start+abort together in IDLE (start wins); start ignored in RUN and DONE.
    v_idle(1'b1, 1'b1, 1'b0);
    for (int a = 0; a < 16; a++) v_read(a, (a == 4));
    v_drain();
    v_done(1'b1);
    v_idle(1'b0, 1'b0, 1'b0);
    v_idle(1'b0, 1'b0, 1'b0);
    run_vecs("ignore");
    chk_wins4("ignore");

    // Reset mid-RUN with start held high, then a fresh frame from address 0.
    v_idle(1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 5; a++) v_read(a, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    prev_rd = -1;
    v_idle(1'b1, 1'b0, 1'b1);
    for (int a = 0; a < 16; a++) v_read(a, 1'b0);
    v_drain();
    v_done(1'b0);
    v_idle(1'b0, 1'b0, 1'b0);
    run_vecs("rstmid");
    chk_wins4("rstmid");

    // 5x3 frame: 15 reads, windows at 6,7,8, done at t0+17.
    done_at = -1;
    ndone   = 0;
    @(posedge clk);
    #1;
    s_start = 1'b1;
    @(negedge clk);
    chk("w53.idle_busy", 32'(s_busy), 32'd0);
    @(posedge clk);
    #1;
    s_start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (s_rd_en === 1'b1) rq.push_back(int'(s_rd_addr));
      if (s_win === 1'b1) wq.push_back(int'(s_out_addr));
      if (s_done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
    end
    chk("w53.read_count", 32'(rq.size()), 32'd15);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("w53.rd_addr%0d", i),
          (i < rq.size()) ? 32'(rq[i]) : 32'hffff_ffff, 32'(i));
    end
    chk("w53.win_count", 32'(wq.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("w53.win_addr%0d", i),
          (i < wq.size()) ? 32'(wq[i]) : 32'hffff_ffff, 32'(exp53[i]));
    end
    chk("w53.done_cycle", 32'(done_at), 32'd17);
    chk("w53.done_count", 32'(ndone), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edge_scan_controller.md
# edge_scan_controller

Raster-scan sequencer for the 3x3 edge-detection datapath in `image_processor`. On a start pulse it walks the input frame in raster order and issues pixel-memory read addresses. It tracks the row/column of each returned pixel and flags when a complete 3x3 window is centred on an interior pixel, supplying that pixel's output address. It also handles downstream stall, abort and frame-done signalling, replacing the free-running index counter inside the processor.

## Interface
- `IMG_W`, 64, frame width in pixels (>= 3)
- `IMG_H`, 64, frame height in pixels (>= 3)
- `ADDR_W`, 12, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- `clk`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a frame; sampled only in IDLE
- `abort`  in  1  terminate the current frame
- `out_ready`  in  1  downstream can accept a window next cycle; low = stall
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse at normal frame completion
- `rd_en`  out  1  pixel-memory read strobe
- `rd_addr`  out  ADDR_W  read address = row*IMG_W + col
- `pix_valid`  out  1  memory data valid this cycle (rd_en delayed 1)
- `win_valid`  out  1  current pixel completes a 3x3 window
- `out_addr`  out  ADDR_W  address of the window centre, valid with `win_valid`

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 -> RUN; row and col counters cleared to 0.
  - `start` is ignored in every other state.
- RUN:
  - `rd_en` = `out_ready` (combinational), so a stall costs exactly one bubble.
  - When `rd_en`=1: `rd_addr` = row*IMG_W+col, then col increments; at col=IMG_W-1, col wraps to 0 and row increments.
  - When `out_ready`=0: counters hold, `rd_en`=0.
  - A read at (IMG_H-1, IMG_W-1) -> DRAIN.
- DRAIN: one cycle; the last read's data returns (`pix_valid`=1). -> DONE.
- DONE: `done`=1 for this cycle only. -> IDLE.
- Return pipeline:
  - Registered copies of `rd_en`, row and col become `pix_valid`, prow and pcol one cycle later.
  - `win_valid` = `pix_valid` & prow>=2 & pcol>=2.
  - `out_addr` = (prow-1)*IMG_W + (pcol-1), registered alongside.
  - Border pixels produce no window: exactly (IMG_W-2)*(IMG_H-2) windows per frame.
- Skid: a read issued while `out_ready`=1 returns next cycle regardless of `out_ready` then. The datapath must absorb one in-flight pixel.
- `abort`:
  - In RUN or DRAIN: -> IDLE next cycle; `pix_valid`, `win_valid` and `rd_en` are forced 0 from that cycle; `done` is not pulsed.
  - Ignored in IDLE and DONE.
  - `abort` and `start` together in IDLE: `start` wins.
- Address arithmetic is unsigned, ADDR_W bits, and cannot overflow given the parameter rule.

## Timing
- Reset (synchronous, dominates all inputs): state IDLE; counters 0; every output 0 (`busy`, `done`, `rd_en`, `rd_addr`, `pix_valid`, `win_valid`, `out_addr`).
- Reset mid-frame: IDLE next edge, no `done`, no further reads.
- `start` sampled at edge t0: RUN from cycle t0+1, first `rd_en` with `rd_addr`=0 in cycle t0+1 (if `out_ready`).
- Read latency 1: `pix_valid`/`win_valid` for a read in cycle t appear in cycle t+1.
- No stalls: N=IMG_W*IMG_H reads in cycles t0+1..t0+N, DRAIN at t0+N+1, `done` at t0+N+2, IDLE at t0+N+3.
- Each stalled cycle delays all subsequent events by exactly one cycle.
- `busy` is low in DONE; a new `start` is accepted at the earliest in the IDLE cycle following `done`.

## Test plan
- IMG_W=IMG_H=4, `out_ready`=1, `start` at t0 -> `rd_addr` 0..15 in cycles t0+1..t0+16, 4 `win_valid` pulses with `out_addr` 5,6,9,10, `done` only at t0+18.
- Same frame with `out_ready` held 0 for 3 cycles after address 6 -> no reads during the stall, read resumes at address 7, `done` at t0+21, identical `out_addr` sequence.
- `abort` asserted after address 9 is read -> IDLE next cycle, `busy`=0, no `done`, no `win_valid` afterwards.
- `reset` asserted mid-RUN while `start` is held high -> all outputs 0 next cycle; after reset release, the held `start` begins a fresh frame at `rd_addr` 0.
- `start` pulsed while in RUN and while in DONE -> ignored; exactly one `done` per accepted start.
- IMG_W=5, IMG_H=3 -> 15 reads, 3 windows at `out_addr` 6,7,8; row wrap verified at addresses 4->5 and 9->10.
